// File: rtl/mcs_di_bridge.sv
// MCS IO bus to DI terminal bus bridge.
// Carries one single-word read or write at a time from the MCS IO port to a DI
// terminal, with a terminal-ready timeout and a pulse for strobes that arrive
// while a transfer is already in flight.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for an MCS read or write strobe
// RD_WAIT  | read mode up, request pulsed, waiting for di_read_rdy
// RD_XFER  | di_read pulse, capturing terminal data and status
// WR_WAIT  | write mode up, waiting for di_write_rdy
// WR_XFER  | di_write pulse, capturing terminal status
// RESP     | io_ready pulse back to the MCS
module mcs_di_bridge #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_BITS  = 28,
  parameter int          TIMEOUT    = 1024,
  parameter logic [15:0] TO_STATUS  = 16'hFFFF
) (
  input  logic                  ifclk,
  input  logic                  reset,
  input  logic                  io_read_strobe,
  input  logic                  io_write_strobe,
  input  logic [31:0]           io_address,
  input  logic [DATA_WIDTH-1:0] io_write_data,
  output logic [DATA_WIDTH-1:0] io_read_data,
  output logic                  io_ready,
  input  logic [15:0]           mcs_term_addr,
  output logic [15:0]           mcs_transfer_status,
  output logic                  busy_drop,
  output logic                  timeout,
  output logic [15:0]           di_term_addr,
  output logic [31:0]           di_reg_addr,
  output logic [31:0]           di_len,
  output logic                  di_read_mode,
  output logic                  di_read_req,
  output logic                  di_read,
  input  logic                  di_read_rdy,
  input  logic [DATA_WIDTH-1:0] di_reg_datao,
  output logic                  di_write_mode,
  output logic                  di_write,
  input  logic                  di_write_rdy,
  output logic [DATA_WIDTH-1:0] di_reg_datai,
  input  logic [15:0]           di_transfer_status
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_XFER,
    ST_WR_WAIT,
    ST_WR_XFER,
    ST_RESP
  } state_t;

  // Down-counter loaded with TIMEOUT-1 on accept; abort when it hits zero.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   word_addr;
  logic          to_expired;

  assign word_addr  = {{(32 - ADDR_BITS){1'b0}}, io_address[ADDR_BITS+1:2]};
  assign to_expired = (TIMEOUT > 0) && (wait_cnt == '0);

  // Burst length is fixed at one word.
  assign di_len = 32'd1;

  // Transfer sequencer with registered outputs and latched request fields.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state               <= ST_IDLE;
      wait_cnt            <= '0;
      io_read_data        <= '0;
      io_ready            <= 1'b0;
      mcs_transfer_status <= '0;
      busy_drop           <= 1'b0;
      timeout             <= 1'b0;
      di_term_addr        <= '0;
      di_reg_addr         <= '0;
      di_read_mode        <= 1'b0;
      di_read_req         <= 1'b0;
      di_read             <= 1'b0;
      di_write_mode       <= 1'b0;
      di_write            <= 1'b0;
      di_reg_datai        <= '0;
    end else begin
      di_read_req <= 1'b0;
      di_read     <= 1'b0;
      di_write    <= 1'b0;
      io_ready    <= 1'b0;
      busy_drop   <= 1'b0;
      timeout     <= 1'b0;

      if (state != ST_IDLE && (io_read_strobe || io_write_strobe))
        busy_drop <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (io_read_strobe) begin
            di_reg_addr  <= word_addr;
            di_term_addr <= mcs_term_addr;
            di_read_mode <= 1'b1;
            di_read_req  <= 1'b1;
            wait_cnt     <= TO_LOAD;
            state        <= ST_RD_WAIT;
            // read has priority; a coincident write is dropped
            if (io_write_strobe)
              busy_drop <= 1'b1;
          end else if (io_write_strobe) begin
            di_reg_addr   <= word_addr;
            di_term_addr  <= mcs_term_addr;
            di_reg_datai  <= io_write_data;
            di_write_mode <= 1'b1;
            wait_cnt      <= TO_LOAD;
            state         <= ST_WR_WAIT;
          end
        end

        ST_RD_WAIT: begin
          // di_read_req is high only in the first wait cycle, so rdy is
          // ignored until the terminal has seen the request.
          if (!di_read_req && di_read_rdy) begin
            di_read <= 1'b1;
            state   <= ST_RD_XFER;
          end else if (to_expired) begin
            io_ready            <= 1'b1;
            timeout             <= 1'b1;
            mcs_transfer_status <= TO_STATUS;
            io_read_data        <= '0;
            di_read_mode        <= 1'b0;
            state               <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_RD_XFER: begin
          io_read_data        <= di_reg_datao;
          mcs_transfer_status <= di_transfer_status;
          io_ready            <= 1'b1;
          di_read_mode        <= 1'b0;
          state               <= ST_RESP;
        end

        ST_WR_WAIT: begin
          if (di_write_rdy) begin
            di_write <= 1'b1;
            state    <= ST_WR_XFER;
          end else if (to_expired) begin
            io_ready            <= 1'b1;
            timeout             <= 1'b1;
            mcs_transfer_status <= TO_STATUS;
            io_read_data        <= '0;
            di_write_mode       <= 1'b0;
            state               <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_WR_XFER: begin
          mcs_transfer_status <= di_transfer_status;
          io_ready            <= 1'b1;
          di_write_mode       <= 1'b0;
          state               <= ST_RESP;
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs_di_bridge.sv
// Bench for mcs_di_bridge: scoreboard of expected completions plus pulse
// counters and latency checks around each scenario.
module tb_mcs_di_bridge;

  localparam int DW = 32;

  logic          ifclk = 1'b0;
  logic          reset;
  logic          io_read_strobe;
  logic          io_write_strobe;
  logic [31:0]   io_address;
  logic [DW-1:0] io_write_data;
  logic [DW-1:0] io_read_data;
  logic          io_ready;
  logic [15:0]   mcs_term_addr;
  logic [15:0]   mcs_transfer_status;
  logic          busy_drop;
  logic          timeout;
  logic [15:0]   di_term_addr;
  logic [31:0]   di_reg_addr;
  logic [31:0]   di_len;
  logic          di_read_mode;
  logic          di_read_req;
  logic          di_read;
  logic          di_read_rdy;
  logic [DW-1:0] di_reg_datao;
  logic          di_write_mode;
  logic          di_write;
  logic          di_write_rdy;
  logic [DW-1:0] di_reg_datai;
  logic [15:0]   di_transfer_status;

  mcs_di_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (28),
    .TIMEOUT   (16),
    .TO_STATUS (16'hFFFF)
  ) dut (
    .ifclk              (ifclk),
    .reset              (reset),
    .io_read_strobe     (io_read_strobe),
    .io_write_strobe    (io_write_strobe),
    .io_address         (io_address),
    .io_write_data      (io_write_data),
    .io_read_data       (io_read_data),
    .io_ready           (io_ready),
    .mcs_term_addr      (mcs_term_addr),
    .mcs_transfer_status(mcs_transfer_status),
    .busy_drop          (busy_drop),
    .timeout            (timeout),
    .di_term_addr       (di_term_addr),
    .di_reg_addr        (di_reg_addr),
    .di_len             (di_len),
    .di_read_mode       (di_read_mode),
    .di_read_req        (di_read_req),
    .di_read            (di_read),
    .di_read_rdy        (di_read_rdy),
    .di_reg_datao       (di_reg_datao),
    .di_write_mode      (di_write_mode),
    .di_write           (di_write),
    .di_write_rdy       (di_write_rdy),
    .di_reg_datai       (di_reg_datai),
    .di_transfer_status (di_transfer_status)
  );

  always #5 ifclk = ~ifclk;

  typedef struct {
    logic          is_rd;
    logic [DW-1:0] data;
    logic [15:0]   status;
    logic          to;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ready_cnt = 0;
  int            ready_cyc = 0;
  int            rd_pulses = 0;
  int            wr_pulses = 0;
  int            wr_cyc = 0;
  int            drop_cnt = 0;
  int            strobe_cyc = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge ifclk) cyc <= cyc + 1;

  // Output monitor: pulse counting and scoreboard pops on io_ready.
  always @(negedge ifclk) begin
    if (!reset) begin
      if (di_read) rd_pulses++;
      if (di_write) begin
        wr_pulses++;
        wr_cyc = cyc;
      end
      if (busy_drop) drop_cnt++;
      if (io_ready) begin
        ready_cnt++;
        ready_cyc = cyc;
        if (sb.size() == 0) begin
          check_val("unexpected_ready", 32'd1, 32'd0);
        end else begin
          popped = sb.pop_front();
          check_val("rdata", io_read_data, popped.data);
          check_val("status", {16'd0, mcs_transfer_status}, {16'd0, popped.status});
          check_val("timeout_flag", {31'd0, timeout}, {31'd0, popped.to});
        end
      end
    end
  end

  task automatic do_strobe(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [DW-1:0] data, input logic [15:0] term);
    @(posedge ifclk); #1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_address      = addr;
    io_write_data   = data;
    mcs_term_addr   = term;
    strobe_cyc      = cyc;
    @(posedge ifclk); #1;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  task automatic push_rd(input logic [DW-1:0] data, input logic [15:0] status,
                         input logic to);
    exp_t e;
    e.is_rd = 1'b1; e.data = data; e.status = status; e.to = to;
    last_rd = data;
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] status);
    exp_t e;
    e.is_rd = 1'b0; e.data = last_rd; e.status = status; e.to = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int base, input int budget);
    int n;
    n = 0;
    while (ready_cnt == base && n < budget) begin
      @(negedge ifclk);
      n++;
    end
    if (ready_cnt == base) check_val("ready_wait_expired", 32'd0, 32'd1);
    repeat (2) @(negedge ifclk);
  endtask

  initial begin
    int base, rd0, wr0, dr0, rcyc;

    reset = 1'b1;
    io_read_strobe = 1'b0; io_write_strobe = 1'b0;
    io_address = '0; io_write_data = '0; mcs_term_addr = '0;
    di_read_rdy = 1'b0; di_write_rdy = 1'b0;
    di_reg_datao = '0; di_transfer_status = '0;
    repeat (3) @(posedge ifclk);
    #1 reset = 1'b0;
    @(negedge ifclk);
    check_val("rst_io_ready", {31'd0, io_ready}, 32'd0);
    check_val("rst_rdata", io_read_data, 32'd0);
    check_val("rst_status", {16'd0, mcs_transfer_status}, 32'd0);
    check_val("rst_modes", {30'd0, di_read_mode, di_write_mode}, 32'd0);
    check_val("rst_di_len", di_len, 32'd1);

    // plain read, rdy already high
    di_read_rdy = 1'b1; di_reg_datao = 32'hDEADBEEF; di_transfer_status = 16'h00A5;
    base = ready_cnt; rd0 = rd_pulses;
    push_rd(32'hDEADBEEF, 16'h00A5, 1'b0);
    do_strobe(1'b1, 1'b0, 32'hC0000010, '0, 16'd5);
    check_val("rd_req_first", {30'd0, di_read_mode, di_read_req}, 32'd3);
    wait_ready(base, 40);
    check_val("rd_latency", ready_cyc - strobe_cyc, 32'd4);
    check_val("rd_reg_addr", di_reg_addr, 32'd4);
    check_val("rd_term", {16'd0, di_term_addr}, 32'd5);
    check_val("rd_pulses", rd_pulses - rd0, 32'd1);
    check_val("rd_mode_drop", {31'd0, di_read_mode}, 32'd0);

    // write with rdy held low for 10 cycles
    di_read_rdy = 1'b0; di_transfer_status = 16'h0042;
    base = ready_cnt; rd0 = rd_pulses; wr0 = wr_pulses;
    push_wr(16'h0042);
    do_strobe(1'b0, 1'b1, 32'h00000100, 32'h12345678, 16'd7);
    repeat (9) @(posedge ifclk);
    #1 di_write_rdy = 1'b1; rcyc = cyc;
    wait_ready(base, 40);
    di_write_rdy = 1'b0;
    check_val("wr_pulse_cyc", wr_cyc - rcyc, 32'd1);
    check_val("wr_ready_cyc", ready_cyc - rcyc, 32'd2);
    check_val("wr_datai", di_reg_datai, 32'h12345678);
    check_val("wr_reg_addr", di_reg_addr, 32'h40);
    check_val("wr_pulses", wr_pulses - wr0, 32'd1);
    check_val("wr_no_read", rd_pulses - rd0, 32'd0);

    // read timeout, rdy never rises
    di_reg_datao = 32'h5555AAAA; di_transfer_status = 16'h0011;
    base = ready_cnt; rd0 = rd_pulses;
    push_rd('0, 16'hFFFF, 1'b1);
    do_strobe(1'b1, 1'b0, 32'h00000020, '0, 16'd3);
    wait_ready(base, 60);
    check_val("to_latency", ready_cyc - strobe_cyc, 32'd17);
    check_val("to_no_read", rd_pulses - rd0, 32'd0);

    // write strobe during RD_WAIT is dropped
    di_reg_datao = 32'hCAFEF00D; di_transfer_status = 16'h0007;
    base = ready_cnt; rd0 = rd_pulses; wr0 = wr_pulses; dr0 = drop_cnt;
    push_rd(32'hCAFEF00D, 16'h0007, 1'b0);
    do_strobe(1'b1, 1'b0, 32'h00000400, '0, 16'd9);
    do_strobe(1'b0, 1'b1, 32'h00000800, 32'hFFFFFFFF, 16'd1);
    #1 di_read_rdy = 1'b1;
    wait_ready(base, 40);
    check_val("busy_drop_cnt", drop_cnt - dr0, 32'd1);
    check_val("busy_no_write", wr_pulses - wr0, 32'd0);
    check_val("busy_rd_pulses", rd_pulses - rd0, 32'd1);
    check_val("busy_addr_held", di_reg_addr, 32'h100);
    check_val("busy_term_held", {16'd0, di_term_addr}, 32'd9);

    // simultaneous strobes: read wins
    di_reg_datao = 32'h0BADCAFE; di_transfer_status = 16'h0123; di_write_rdy = 1'b1;
    base = ready_cnt; rd0 = rd_pulses; wr0 = wr_pulses; dr0 = drop_cnt;
    push_rd(32'h0BADCAFE, 16'h0123, 1'b0);
    do_strobe(1'b1, 1'b1, 32'h00000030, 32'h77777777, 16'd2);
    wait_ready(base, 40);
    di_write_rdy = 1'b0;
    check_val("both_latency", ready_cyc - strobe_cyc, 32'd4);
    check_val("both_drop", drop_cnt - dr0, 32'd1);
    check_val("both_no_write", wr_pulses - wr0, 32'd0);
    check_val("both_reg_addr", di_reg_addr, 32'hC);

    // reset while in WR_WAIT
    base = ready_cnt;
    do_strobe(1'b0, 1'b1, 32'h00000044, 32'hA5A5A5A5, 16'd4);
    repeat (2) @(posedge ifclk);
    #1 reset = 1'b1;
    @(posedge ifclk);
    #1 reset = 1'b0;
    @(negedge ifclk);
    check_val("rst_mid_mode", {31'd0, di_write_mode}, 32'd0);
    check_val("rst_mid_datai", di_reg_datai, 32'd0);
    check_val("rst_mid_rdata", io_read_data, 32'd0);
    check_val("rst_mid_term", {16'd0, di_term_addr}, 32'd0);
    last_rd = '0;
    repeat (5) @(negedge ifclk);
    check_val("rst_no_ready", ready_cnt - base, 32'd0);

    di_reg_datao = 32'h13579BDF; di_transfer_status = 16'h0055;
    base = ready_cnt;
    push_rd(32'h13579BDF, 16'h0055, 1'b0);
    do_strobe(1'b1, 1'b0, 32'h00000050, '0, 16'd6);
    wait_ready(base, 40);
    check_val("post_rst_latency", ready_cyc - strobe_cyc, 32'd4);
    check_val("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
